// File: rtl/lif_cfg_pkg.sv
// Shared constants and types for the LIF neuron configuration path.
// The neuron top level and the config test harness import this package too.
package lif_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } cfg_state_e;

    localparam logic [2:0] IDX_WEIGHT = 3'd0;
    localparam logic [2:0] IDX_LEAK1  = 3'd1;
    localparam logic [2:0] IDX_LEAK2  = 3'd2;
    localparam logic [2:0] IDX_THRESH = 3'd3;
    localparam logic [2:0] IDX_CYCLES = 3'd4;
    localparam logic [2:0] IDX_CSUM   = 3'd5;

    localparam int unsigned CFG_PAYLOAD_LEN = 5;

    typedef struct packed {
        logic [2:0] weight;
        logic [7:0] leak_rate_1;
        logic [7:0] leak_rate_2;
        logic [7:0] threshold;
        logic [3:0] leak_cycles_1;
        logic [3:0] leak_cycles_2;
    } lif_params_t;

    // Index of the final byte of a frame, which depends on checksum presence.
    function automatic logic [2:0] last_index(input bit csum_en);
        return csum_en ? IDX_CSUM : IDX_CYCLES;
    endfunction

endpackage

// File: rtl/lif_cfg_watchdog.sv
// 8-bit inactivity timer: counts run cycles, clears on demand, and pulses
// timeout_o on the run cycle that brings the count to TIMEOUT_CYCLES.
module lif_cfg_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic run_i,
    output logic timeout_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] timer_q;
    logic [7:0] timer_d;

    always_comb begin
        timer_d = timer_q;
        if (clear_i) begin
            timer_d = '0;
        end else if (run_i) begin
            timer_d = timer_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timeout_o = run_i && !clear_i && (timer_q == LIMIT);

endmodule

// File: rtl/lif_param_loader.sv
// Byte-serial loader for the dual-leak LIF neuron: frames a parameter set,
// verifies its XOR checksum and commits it atomically to the active bank.
module lif_param_loader
    import lif_cfg_pkg::*;
#(
    parameter bit          CHECKSUM_EN    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_start,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic [2:0] weight_a,
    output logic [7:0] leak_rate_1,
    output logic [7:0] leak_rate_2,
    output logic [7:0] threshold,
    output logic [3:0] leak_cycles_1,
    output logic [3:0] leak_cycles_2,
    output logic       params_ready,
    output logic       cfg_error,
    output logic       busy
);

    localparam logic [2:0] LAST_IDX = last_index(CHECKSUM_EN);

    cfg_state_e  state_q,  state_d;
    logic [2:0]  idx_q,    idx_d;
    logic [7:0]  xor_q,    xor_d;
    logic [7:0]  csum_q,   csum_d;
    lif_params_t shadow_q, shadow_d;
    lif_params_t active_q, active_d;
    logic        ready_q,  ready_d;
    logic        err_q,    err_d;

    logic hs;
    logic wd_clear;
    logic wd_run;
    logic wd_timeout;

    assign cfg_ready = (state_q == LOAD);
    assign hs        = cfg_valid && cfg_ready;

    // A start pulse in LOAD restarts the frame, so it also restarts the idle timer.
    assign wd_clear = (state_q != LOAD) || cfg_start || hs;
    assign wd_run   = !wd_clear;

    lif_cfg_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (wd_clear),
        .run_i    (wd_run),
        .timeout_o(wd_timeout)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        xor_d    = xor_q;
        csum_d   = csum_q;
        shadow_d = shadow_q;
        active_d = active_q;
        ready_d  = ready_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    xor_d   = '0;
                end
            end

            LOAD: begin
                if (cfg_start) begin
                    idx_d = '0;
                    xor_d = '0;
                end else if (hs) begin
                    unique case (idx_q)
                        IDX_WEIGHT: shadow_d.weight      = cfg_data[2:0];
                        IDX_LEAK1:  shadow_d.leak_rate_1 = cfg_data;
                        IDX_LEAK2:  shadow_d.leak_rate_2 = cfg_data;
                        IDX_THRESH: shadow_d.threshold   = cfg_data;
                        IDX_CYCLES: begin
                            shadow_d.leak_cycles_1 = cfg_data[3:0];
                            shadow_d.leak_cycles_2 = cfg_data[7:4];
                        end
                        default:    csum_d = cfg_data;
                    endcase
                    if (idx_q != IDX_CSUM) begin
                        xor_d = xor_q ^ cfg_data;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else if (wd_timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end

            CHECK: begin
                if (!CHECKSUM_EN || (csum_q == xor_q)) begin
                    active_d = shadow_q;
                    ready_d  = 1'b1;
                    err_d    = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            xor_q    <= '0;
            csum_q   <= '0;
            shadow_q <= '0;
            active_q <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            xor_q    <= xor_d;
            csum_q   <= csum_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    assign weight_a      = active_q.weight;
    assign leak_rate_1   = active_q.leak_rate_1;
    assign leak_rate_2   = active_q.leak_rate_2;
    assign threshold     = active_q.threshold;
    assign leak_cycles_1 = active_q.leak_cycles_1;
    assign leak_cycles_2 = active_q.leak_cycles_2;
    assign params_ready  = ready_q;
    assign cfg_error     = err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_lif_param_loader.sv
// Bench for lif_param_loader: table of frames through a scoreboard, plus
// hand-written timeout, restart, reset and no-checksum sequences.
module tb_lif_param_loader;

    typedef struct packed {
        logic [2:0] w;
        logic [7:0] l1;
        logic [7:0] l2;
        logic [7:0] th;
        logic [3:0] c1;
        logic [3:0] c2;
        logic       pr;
        logic       err;
    } exp_t;

    typedef struct {
        logic [47:0] bytes;
        bit          gaps;
        exp_t        exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_start, cfg_valid, cfg_ready;
    logic [7:0] cfg_data;
    logic [2:0] weight_a;
    logic [7:0] leak_rate_1, leak_rate_2, threshold;
    logic [3:0] leak_cycles_1, leak_cycles_2;
    logic       params_ready, cfg_error, busy;

    logic       n_start, n_valid, n_ready;
    logic [7:0] n_data;
    logic [2:0] n_weight;
    logic [7:0] n_l1, n_l2, n_th;
    logic [3:0] n_c1, n_c2;
    logic       n_pr, n_err, n_busy;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];
    exp_t cur;
    exp_t act, act_nc;
    bit   pr_seen = 1'b0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    lif_param_loader #(.CHECKSUM_EN(1'b1), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .weight_a(weight_a),
        .leak_rate_1(leak_rate_1), .leak_rate_2(leak_rate_2), .threshold(threshold),
        .leak_cycles_1(leak_cycles_1), .leak_cycles_2(leak_cycles_2),
        .params_ready(params_ready), .cfg_error(cfg_error), .busy(busy)
    );

    lif_param_loader #(.CHECKSUM_EN(1'b0), .TIMEOUT_CYCLES(255)) dut_nc (
        .clk(clk), .reset(reset), .cfg_start(n_start), .cfg_data(n_data),
        .cfg_valid(n_valid), .cfg_ready(n_ready), .weight_a(n_weight),
        .leak_rate_1(n_l1), .leak_rate_2(n_l2), .threshold(n_th),
        .leak_cycles_1(n_c1), .leak_cycles_2(n_c2),
        .params_ready(n_pr), .cfg_error(n_err), .busy(n_busy)
    );

    assign act    = {weight_a, leak_rate_1, leak_rate_2, threshold,
                     leak_cycles_1, leak_cycles_2, params_ready, cfg_error};
    assign act_nc = {n_weight, n_l1, n_l2, n_th, n_c1, n_c2, n_pr, n_err};

    function automatic exp_t mk(input logic [2:0] w, input logic [7:0] l1, input logic [7:0] l2,
                                input logic [7:0] th, input logic [3:0] c1, input logic [3:0] c2,
                                input logic pr, input logic err);
        return {w, l1, l2, th, c1, c2, pr, err};
    endfunction

    task automatic check_bit(input string name, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: actual=%0b expected=%0b", name, a, e);
        end
    endtask

    task automatic check_params(input string name, input exp_t a, input exp_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h (w,l1,l2,th,c1,c2,pr,err)", name, a, e);
        end
    endtask

    // params_ready is sticky: once seen high it may only fall through reset.
    always @(negedge clk) begin
        if (reset) begin
            pr_seen = 1'b0;
        end else if (pr_seen) begin
            checks++;
            if (!params_ready) begin
                errors++;
                $display("FAIL pr_sticky: actual=0 expected=1 at %0t", $time);
            end
        end else if (params_ready) begin
            pr_seen = 1'b1;
        end
    end

    task automatic pulse_start(input bit nc);
        if (nc) n_start = 1'b1; else cfg_start = 1'b1;
        @(posedge clk); #1;
        n_start   = 1'b0;
        cfg_start = 1'b0;
    endtask

    // Returns #1 after the edge that transfers the byte.
    task automatic send_byte(input bit nc, input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        if (nc) begin n_data = b; n_valid = 1'b1; end
        else begin cfg_data = b; cfg_valid = 1'b1; end
        @(negedge clk);
        while (!(nc ? n_ready : cfg_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(nc ? n_ready : cfg_ready)) begin
            checks++;
            errors++;
            $display("FAIL handshake_wait: actual=ready_low expected=ready_high");
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        n_valid   = 1'b0;
    endtask

    task automatic send_frame(input vec_t v, input bit do_start);
        exp_t e;
        sbq.push_back(v.exp);
        if (do_start) pulse_start(1'b0);
        for (int i = 0; i < 6; i++) begin
            send_byte(1'b0, v.bytes[47 - 8*i -: 8], v.gaps ? int'($urandom_range(1, 10)) : 0);
        end
        check_params("check_cycle_hold", act, cur);
        check_bit("check_cycle_busy", busy, 1'b1);
        @(posedge clk); #1;
        e = sbq.pop_front();
        check_params("frame_commit", act, e);
        check_bit("frame_busy_done", busy, 1'b0);
        cur = e;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vecs[0] = '{bytes: 48'h05_10_02_80_31_A7, gaps: 1'b0, exp: mk(3'd0, 8'h00, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0, 1'b1)};
        vecs[1] = '{bytes: 48'h05_10_02_80_31_A6, gaps: 1'b0, exp: mk(3'd5, 8'h10, 8'h02, 8'h80, 4'd1, 4'd3, 1'b1, 1'b0)};
        vecs[2] = '{bytes: 48'h03_44_55_66_A9_DD, gaps: 1'b1, exp: mk(3'd3, 8'h44, 8'h55, 8'h66, 4'd9, 4'hA, 1'b1, 1'b0)};
        vecs[3] = '{bytes: 48'hFD_10_02_80_31_5E, gaps: 1'b1, exp: mk(3'd5, 8'h10, 8'h02, 8'h80, 4'd1, 4'd3, 1'b1, 1'b0)};
        vecs[4] = '{bytes: 48'h01_02_03_04_05_00, gaps: 1'b0, exp: mk(3'd5, 8'h10, 8'h02, 8'h80, 4'd1, 4'd3, 1'b1, 1'b1)};
        vecs[5] = '{bytes: 48'h01_02_03_04_05_01, gaps: 1'b1, exp: mk(3'd1, 8'h02, 8'h03, 8'h04, 4'd5, 4'd0, 1'b1, 1'b0)};

        reset = 1'b1;
        cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        n_start = 1'b0;   n_valid = 1'b0;   n_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        cur = '0;
        check_params("reset_outputs", act, cur);
        check_bit("reset_busy", busy, 1'b0);

        // Valid bytes in IDLE must be ignored.
        cfg_valid = 1'b1; cfg_data = 8'h55;
        @(negedge clk);
        check_bit("idle_ready_low", cfg_ready, 1'b0);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check_bit("idle_stays_idle", busy, 1'b0);

        foreach (vecs[i]) send_frame(vecs[i], 1'b1);

        // Inactivity timeout after three bytes.
        pulse_start(1'b0);
        send_byte(1'b0, 8'h11, 0);
        send_byte(1'b0, 8'h22, 0);
        send_byte(1'b0, 8'h33, 0);
        repeat (254) @(posedge clk);
        #1 check_bit("timeout_not_yet", busy, 1'b1);
        @(posedge clk); #1;
        check_bit("timeout_busy", busy, 1'b0);
        cur.err = 1'b1;
        check_params("timeout_hold", act, cur);

        // Restart mid-frame; the byte offered alongside cfg_start is dropped.
        pulse_start(1'b0);
        send_byte(1'b0, 8'hAA, 0);
        send_byte(1'b0, 8'hBB, 0);
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hFF;
        @(negedge clk);
        check_bit("restart_ready_high", cfg_ready, 1'b1);
        @(posedge clk); #1;
        cfg_start = 1'b0; cfg_valid = 1'b0;
        send_frame('{bytes: 48'h07_20_04_40_52_31, gaps: 1'b0,
                     exp: mk(3'd7, 8'h20, 8'h04, 8'h40, 4'd2, 4'd5, 1'b1, 1'b0)}, 1'b0);

        // Reset during LOAD.
        pulse_start(1'b0);
        send_byte(1'b0, 8'h01, 0);
        send_byte(1'b0, 8'h02, 0);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        cur = '0;
        check_params("reset_in_load", act, cur);
        check_bit("reset_in_load_busy", busy, 1'b0);

        // Reset during CHECK must win over the pending commit.
        send_frame(vecs[1], 1'b1);
        pulse_start(1'b0);
        for (int i = 0; i < 6; i++) send_byte(1'b0, vecs[2].bytes[47 - 8*i -: 8], 0);
        check_bit("in_check_busy", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        cur = '0;
        check_params("reset_in_check", act, cur);
        check_bit("reset_in_check_busy", busy, 1'b0);

        // No-checksum build: five bytes commit directly.
        pulse_start(1'b1);
        send_byte(1'b1, 8'h05, 0);
        send_byte(1'b1, 8'h10, 0);
        send_byte(1'b1, 8'h02, 0);
        send_byte(1'b1, 8'h80, 0);
        send_byte(1'b1, 8'h31, 0);
        check_bit("nc_check_busy", n_busy, 1'b1);
        check_bit("nc_check_ready_low", n_ready, 1'b0);
        @(posedge clk); #1;
        check_params("nc_commit", act_nc, mk(3'd5, 8'h10, 8'h02, 8'h80, 4'd1, 4'd3, 1'b1, 1'b0));
        check_bit("nc_busy_done", n_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
